// File: rtl/demux_pkg.sv
// Shared lane constants and round-robin helper for the demux lane collector.
// The grant function is used by the collector's output arbiter.
package demux_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_SEL_W = 2;

    typedef logic [LANE_SEL_W-1:0] lane_t;

    // First full lane at or after ptr, searching upward with wrap 3->0.
    function automatic lane_t rr_next(
        input lane_t                ptr,
        input logic [NUM_LANES-1:0] full_mask
    );
        lane_t grant;
        lane_t idx;
        logic  found;
        grant = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            idx = ptr + lane_t'(i);
            if (!found && full_mask[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/demux_lane_shifter.sv
// One lane of the collector: serial-to-parallel shifter, bit counter,
// single-entry holding register and sticky overflow flag.
module demux_lane_shifter
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap,
    input  logic             bit_in,
    input  logic             drain,
    input  logic             err_clr,
    output logic             full,
    output logic [WIDTH-1:0] hold_data,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] word;
    logic             last_bit;

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        hold_d   = hold_q;
        full_d   = full_q;
        ovf_d    = ovf_q;
        word     = {shreg_q[WIDTH-2:0], bit_in};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));

        if (err_clr) begin
            ovf_d = 1'b0;
        end
        if (drain) begin
            full_d = 1'b0;
        end

        if (cap) begin
            shreg_d = word;
            if (last_bit) begin
                cnt_d = '0;
                // A drain on this same edge frees the slot for the new word.
                if (full_q && !drain) begin
                    ovf_d = 1'b1;
                end else begin
                    hold_d = word;
                    full_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
        end
    end

    assign full      = full_q;
    assign hold_data = hold_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/demux_lane_collector.sv
// Collects the four demux lanes into words and presents them on one
// valid/ready port with round-robin arbitration and sticky error flags.
module demux_lane_collector
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_valid,
    input  logic [1:0]       sel,
    input  logic [3:0]       lane_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       out_lane,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       overflow,
    output logic             protocol_err,
    input  logic             err_clr
);

    logic [NUM_LANES-1:0] cap;
    logic [NUM_LANES-1:0] drain;
    logic [NUM_LANES-1:0] full_mask;
    logic [NUM_LANES-1:0] ovf;
    logic [WIDTH-1:0]     hold_data [NUM_LANES];
    logic                 bit_in;

    assign bit_in = lane_in[sel];

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign cap[k] = bit_valid && (sel == lane_t'(k));

        demux_lane_shifter #(
            .WIDTH(WIDTH)
        ) u_shifter (
            .clk      (clk),
            .rst      (rst),
            .cap      (cap[k]),
            .bit_in   (bit_in),
            .drain    (drain[k]),
            .err_clr  (err_clr),
            .full     (full_mask[k]),
            .hold_data(hold_data[k]),
            .overflow (ovf[k])
        );
    end

    lane_t            ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    lane_t            out_lane_q, out_lane_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             perr_q, perr_d;
    lane_t            grant;
    logic             load;
    logic [3:0]       sel_mask;
    logic             perr_evt;

    always_comb begin
        sel_mask = 4'b0001 << sel;
        perr_evt = bit_valid && ((lane_in & ~sel_mask) != 4'b0000);
        perr_d   = perr_q;
        if (err_clr) begin
            perr_d = 1'b0;
        end
        if (perr_evt) begin
            perr_d = 1'b1;
        end
    end

    always_comb begin
        grant       = rr_next(ptr_q, full_mask);
        load        = (!out_valid_q || out_ready) && (|full_mask);
        drain       = '0;
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_lane_d  = out_lane_q;
        out_data_d  = out_data_q;

        if (load) begin
            drain[grant] = 1'b1;
            out_valid_d  = 1'b1;
            out_lane_d   = grant;
            out_data_d   = hold_data[grant];
            ptr_d        = grant + lane_t'(1);
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_lane_q  <= '0;
            out_data_q  <= '0;
            perr_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_lane_q  <= out_lane_d;
            out_data_q  <= out_data_d;
            perr_q      <= perr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_lane     = out_lane_q;
    assign out_data     = out_data_q;
    assign overflow     = ovf;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_demux_lane_collector.sv
// Self-checking bench for demux_lane_collector: vector table, directed
// corner sequences and randomized traffic against a queue-level model.
module tb_demux_lane_collector;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_valid;
    logic [1:0]   sel;
    logic [3:0]   lane_in;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_lane;
    logic [W-1:0] out_data;
    logic [3:0]   overflow;
    logic         protocol_err;
    logic         err_clr;

    demux_lane_collector #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_valid   (bit_valid),
        .sel         (sel),
        .lane_in     (lane_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lane    (out_lane),
        .out_data    (out_data),
        .overflow    (overflow),
        .protocol_err(protocol_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: per-lane bit counts and words, one pending word per
    // lane, and a single output slot served round-robin.
    int          m_cnt  [4];
    logic [31:0] m_sh   [4];
    bit          m_full [4];
    logic [31:0] m_hold [4];
    bit          m_v;
    int          m_lane;
    logic [31:0] m_data;
    int          m_ptr;
    logic [3:0]  m_ovf;
    bit          m_perr;

    int          acc_lane [$];
    logic [31:0] acc_data [$];

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k] = 0; m_sh[k] = 0; m_full[k] = 0; m_hold[k] = 0;
        end
        m_v = 0; m_lane = 0; m_data = 0; m_ptr = 0; m_ovf = 0; m_perr = 0;
    endtask

    task automatic model_step(input bit bv, input int s, input logic [3:0] lin,
                              input bit ordy, input bit clr);
        bit          any;
        int          g;
        bit          perr_evt;
        logic [3:0]  ovf_evt;
        logic [3:0]  sm;
        logic [31:0] mask;
        mask = (32'd1 << W) - 1;
        any = 0;
        for (int k = 0; k < 4; k++) if (m_full[k]) any = 1;
        if ((!m_v || ordy) && any) begin
            g = -1;
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (g < 0 && m_full[k]) g = k;
            end
            m_v = 1; m_lane = g; m_data = m_hold[g];
            m_full[g] = 0; m_ptr = (g + 1) % 4;
        end else if (ordy) begin
            m_v = 0;
        end
        perr_evt = 0;
        ovf_evt  = 0;
        if (bv) begin
            sm = 4'b0001 << s;
            if ((lin & ~sm) != 0) perr_evt = 1;
            m_sh[s] = ((m_sh[s] << 1) | 32'(lin[s])) & mask;
            m_cnt[s]++;
            if (m_cnt[s] == W) begin
                m_cnt[s] = 0;
                if (m_full[s]) ovf_evt[s] = 1;
                else begin m_hold[s] = m_sh[s]; m_full[s] = 1; end
            end
        end
        if (clr) begin m_ovf = 0; m_perr = 0; end
        m_ovf = m_ovf | ovf_evt;
        if (perr_evt) m_perr = 1;
    endtask

    task automatic step(input bit bv, input int s, input logic [3:0] lin,
                        input bit ordy, input bit clr);
        bit_valid = bv; sel = 2'(s); lane_in = lin; out_ready = ordy; err_clr = clr;
        if (out_valid && ordy) begin
            acc_lane.push_back(int'(out_lane));
            acc_data.push_back(32'(out_data));
        end
        model_step(bv, s, lin, ordy, clr);
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_v));
        chk("out_lane", 32'(out_lane), 32'(m_lane));
        chk("out_data", 32'(out_data), m_data);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) step(0, 0, 4'b0000, ordy, 0);
    endtask

    task automatic send(input int ln, input logic [31:0] word, input bit ordy);
        for (int i = W - 1; i >= 0; i--)
            step(1, ln, 4'(word[i]) << ln, ordy, 0);
    endtask

    task automatic do_reset();
        bit_valid = 0; sel = 0; lane_in = 0; out_ready = 0; err_clr = 0;
        rst = 1;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_lane", 32'(out_lane), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_perr", 32'(protocol_err), 0);
        rst = 0;
    endtask

    task automatic clear_acc();
        acc_lane.delete();
        acc_data.delete();
    endtask

    typedef struct {
        bit         bv;
        int         s;
        logic [3:0] lin;
        bit         ordy;
        bit         clr;
        bit         ev;
        int         el;
        logic [7:0] ed;
        logic [3:0] eo;
        bit         ep;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [7:0] pat;
        pat = 8'hA6;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1, 2, 4'(pat[7-i]) << 2, 1, 0, 0, 0, 8'h00, 4'h0, 0};
        tbl[8] = '{0, 0, 4'h0, 1, 0, 1, 2, 8'hA6, 4'h0, 0};
        tbl[9] = '{0, 0, 4'h0, 1, 0, 0, 2, 8'hA6, 4'h0, 0};

        rst = 1;
        do_reset();

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].bv, tbl[i].s, tbl[i].lin, tbl[i].ordy, tbl[i].clr);
            chk("tbl_valid", 32'(out_valid), 32'(tbl[i].ev));
            chk("tbl_lane", 32'(out_lane), 32'(tbl[i].el));
            chk("tbl_data", 32'(out_data), 32'(tbl[i].ed));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].eo));
            chk("tbl_perr", 32'(protocol_err), 32'(tbl[i].ep));
        end

        // Interleaved lanes 0 and 1
        clear_acc();
        begin
            logic [7:0] w0, w1;
            w0 = 8'h3C; w1 = 8'hF0;
            for (int i = 7; i >= 0; i--) begin
                step(1, 0, 4'(w0[i]), 1, 0);
                step(1, 1, 4'(w1[i]) << 1, 1, 0);
            end
        end
        idle(4, 1);
        chk("il_count", 32'(acc_lane.size()), 2);
        if (acc_lane.size() == 2) begin
            chk("il_lane0", 32'(acc_lane[0]), 0);
            chk("il_data0", acc_data[0], 32'h3C);
            chk("il_lane1", 32'(acc_lane[1]), 1);
            chk("il_data1", acc_data[1], 32'hF0);
        end

        // Round-robin order
        clear_acc();
        send(0, 32'h11, 0);
        send(1, 32'h22, 0);
        send(3, 32'h33, 0);
        idle(2, 0);
        idle(5, 1);
        chk("rr_count", 32'(acc_lane.size()), 3);
        if (acc_lane.size() == 3) begin
            chk("rr_lane0", 32'(acc_lane[0]), 0);
            chk("rr_lane1", 32'(acc_lane[1]), 1);
            chk("rr_lane2", 32'(acc_lane[2]), 3);
            chk("rr_data2", acc_data[2], 32'h33);
        end
        clear_acc();
        send(3, 32'h44, 0);
        send(3, 32'h55, 0);
        send(0, 32'h66, 0);
        idle(2, 0);
        idle(5, 1);
        chk("rr2_count", 32'(acc_lane.size()), 3);
        if (acc_lane.size() == 3) begin
            chk("rr2_lane0", 32'(acc_lane[0]), 3);
            chk("rr2_lane1", 32'(acc_lane[1]), 0);
            chk("rr2_data1", acc_data[1], 32'h66);
            chk("rr2_lane2", 32'(acc_lane[2]), 3);
            chk("rr2_data2", acc_data[2], 32'h55);
        end

        // Backpressure and overflow
        do_reset();
        clear_acc();
        send(1, 32'hA1, 0);
        send(1, 32'hB2, 0);
        send(1, 32'hC3, 0);
        idle(1, 0);
        chk("bp_ovf", 32'(overflow), 32'h2);
        chk("bp_hold", 32'(out_data), 32'hA1);
        idle(4, 1);
        chk("bp_count", 32'(acc_lane.size()), 2);
        if (acc_data.size() == 2) begin
            chk("bp_data0", acc_data[0], 32'hA1);
            chk("bp_data1", acc_data[1], 32'hB2);
        end
        step(0, 0, 4'b0000, 1, 1);
        chk("bp_clr", 32'(overflow), 0);

        // Protocol violation, bit still captured from selected lane
        clear_acc();
        step(1, 0, 4'b0100, 1, 0);
        chk("pe_set", 32'(protocol_err), 1);
        begin
            logic [7:0] w;
            w = 8'h5A;
            for (int i = 6; i >= 0; i--) step(1, 0, 4'(w[i]), 1, 0);
        end
        idle(3, 1);
        chk("pe_count", 32'(acc_lane.size()), 1);
        if (acc_data.size() == 1) chk("pe_word", acc_data[0], 32'h5A);
        step(0, 0, 4'b0000, 1, 1);
        chk("pe_clr", 32'(protocol_err), 0);

        // Asynchronous reset mid-word
        send(0, 32'h77, 0);
        idle(2, 0);
        for (int i = 0; i < 5; i++)
            step(1, 2, (i == 2) ? 4'b0101 : 4'b0100, 0, 0);
        chk("ar_pre_valid", 32'(out_valid), 1);
        #2;
        rst = 1;
        #1;
        chk("ar_valid", 32'(out_valid), 0);
        chk("ar_data", 32'(out_data), 0);
        chk("ar_lane", 32'(out_lane), 0);
        chk("ar_perr", 32'(protocol_err), 0);
        chk("ar_ovf", 32'(overflow), 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        clear_acc();
        idle(3, 1);
        for (int i = 0; i < 3; i++) step(1, 2, 4'b0100, 1, 0);
        idle(4, 1);
        chk("ar_none", 32'(acc_lane.size()), 0);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit         bv, ordy, clr;
            int         s;
            logic [3:0] lin;
            bv   = ($urandom % 4) != 0;
            s    = int'($urandom % 4);
            lin  = 4'($urandom % 2) << s;
            if (($urandom % 16) == 0) lin = lin | 4'($urandom % 16);
            ordy = ((n / 64) % 3 == 2) ? (($urandom % 8) == 0) : (($urandom % 3) != 0);
            clr  = ($urandom % 32) == 0;
            step(bv, s, lin, ordy, clr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_lane_collector.md
Name: demux_lane_collector

Overview:
- Downstream consumer of the 1:4 demultiplexer stage.
- Samples the four demux outputs at each qualified bit strobe and accumulates each lane's serial bits into its own WIDTH-bit word.
- Presents completed words one at a time on a single valid/ready output port, using round-robin arbitration across lanes.
- Flags per-lane overflow and demux protocol violations (a bit set on a non-selected lane).

Parameters:
- WIDTH, 8, bits per assembled word (legal range 2..32).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- bit_valid  in  1  qualifies lane_in/sel this cycle
- sel  in  2  select value currently driving the demux
- lane_in  in  4  demux outputs {out3,out2,out1,out0}
- out_valid  out  1  completed word available
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_lane  out  2  lane index of presented word
- out_data  out  WIDTH  presented word
- overflow  out  4  sticky per-lane word-dropped flag
- protocol_err  out  1  sticky non-selected-lane-high flag
- err_clr  in  1  synchronous pulse, clears overflow and protocol_err

Behaviour:
- Clocking and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values:
  - out_valid=0, out_lane=0, out_data=0, overflow=0, protocol_err=0.
  - All lane bit counters 0, all shift registers 0, all holding registers empty.
  - Round-robin pointer = lane 0 highest priority.
- Reset mid-word discards every partial word and every held word; nothing is emitted afterwards.
- Bit capture: on a clk edge with bit_valid=1, bit b = lane_in[sel] is shifted MSB-first into lane sel's shift register (shreg <= {shreg[WIDTH-2:0], b}), and that lane's counter increments. Other lanes are untouched.
- Protocol check: with bit_valid=1, any lane_in[k]=1 for k != sel sets protocol_err on the next edge. The bit is still captured normally.
- Word completion: when the accepted bit is the WIDTH-th bit (counter == WIDTH-1):
  - the counter wraps to 0;
  - the assembled word is written to the lane's holding register, which is marked full.
- Holding register occupied:
  - If the holding register is full and is not being drained this same edge, the new word is dropped and overflow[lane] sets. The held word is preserved.
  - Drain and completion on the same lane in the same edge: the new word loads, with no overflow.
- Output stage (registered):
  - Loads when (!out_valid || out_ready) and at least one holding register is full.
  - Grant goes to the first full lane at or after the pointer, searching upward and wrapping 3->0.
  - The granted holding register is cleared, out_lane/out_data are loaded, and out_valid=1.
  - The pointer moves to grant+1 mod 4.
  - If no holding register is full and out_ready=1, out_valid drops to 0.
- Stability: while out_valid && !out_ready, out_lane and out_data hold constant.
- Latency: the final bit is accepted at edge N, the holding register is full after edge N, and the word appears on out_valid after edge N+1. Minimum is 2 cycles from bit strobe to output.
- Throughput: one word per cycle when out_ready is held high.
- err_clr:
  - Clears both sticky flags on the edge it is sampled.
  - A new error event in the same cycle wins, and the flag stays set.
- bit_valid=0: no state changes except the output stage and err_clr.

Decomposition:
- Shared package demux_pkg:
  - NUM_LANES=4, LANE_SEL_W=2;
  - lane index typedef;
  - function rr_next(ptr, full_mask) returning the granted lane.
- Sub-module demux_lane_shifter, instantiated 4x. Each instance contains:
  - the shift register;
  - the bit counter;
  - the holding register with its full flag and drain input;
  - the overflow detection.
- Top level contains the protocol check, round-robin arbiter and output register.

Test Plan:
- Single lane: sel=2, 8 strobes with lane_in[2] bits 1,0,1,0,0,1,1,0 and out_ready=1 -> out_valid 2 cycles after the last strobe, out_lane=2, out_data=8'hA6, single-cycle pulse.
- Interleaved: alternate sel 0/1 strobes, lane0 bits forming 8'h3C and lane1 forming 8'hF0 -> both words emitted with correct lane tags. No cross-lane corruption.
- Round-robin: out_ready=0 while lanes 0,1,3 each complete a word, then out_ready=1 -> order 0,1,3. Refill lanes 0 and 3 -> order 3,0 is not allowed; the pointer after lane 3 yields 0 then 3.
- Backpressure/overflow: out_ready=0, lane 1 completes three words -> the first occupies the output, the second is held, the third sets overflow=4'b0010. After out_ready=1, exactly two words are delivered. err_clr clears the flag.
- Protocol: bit_valid=1, sel=0, lane_in=4'b0100 -> protocol_err=1 next cycle and lane 0 captures bit 0. Reset asserted asynchronously mid-word with 5 bits accumulated -> all outputs 0 immediately, no word emitted after release.
